// File: rtl/decode_ctrl_pipe_if.sv
`default_nettype none
// ============================================================================
// decode_ctrl_pipe_if: D-stage instruction in / control word out handshake.
// Revision: 1.0
// ============================================================================
interface decode_ctrl_pipe_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic        out_valid;
   logic        out_ready;
   logic [21:0] ctrl;

   // master is the surrounding pipeline, slave is the decode stage
   modport master (
      output in_valid, instr, out_ready,
      input  in_ready, out_valid, ctrl
   );
   modport slave (
      input  in_valid, instr, out_ready,
      output in_ready, out_valid, ctrl
   );
endinterface
`default_nettype wire

// File: rtl/decode_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// decode_ctrl_pipe: MIPS32 decode into a one-entry valid/ready slot with a HI/LO busy sequencer.
// Revision: 1.0
// ============================================================================
module decode_ctrl_pipe #(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = $clog2(DIV_CYCLES + 1)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   output logic              md_busy,
   decode_ctrl_pipe_if.slave bus
);

   typedef struct packed {
      logic regwrite, regdst, alusrc, branch, memwrite, memtoreg, memen, jump;
      logic jal, jr, bal, write31, hlwrite, hlread, cp0we, cp0read;
      logic eret, syscall, brk, ri, is_mul, is_div;
   } ctrl_t;

   typedef enum logic [1:0] {
      c_idle = 2'd0,
      c_mul  = 2'd1,
      c_div  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_mul_init = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_div_init = CNT_W'(DIV_CYCLES - 1);

   ctrl_t            w_dec;
   ctrl_t            r_ctrl;
   logic             r_valid;
   state_t           r_state;
   logic [CNT_W-1:0] r_count;
   logic [5:0]       w_op;
   logic [5:0]       w_funct;
   logic [4:0]       w_rs;
   logic [4:0]       w_rt;
   logic             w_hl_block;
   logic             w_accept;
   logic             w_handoff;

   assign w_op    = bus.instr[31:26];
   assign w_rs    = bus.instr[25:21];
   assign w_rt    = bus.instr[20:16];
   assign w_funct = bus.instr[5:0];

   always_comb begin
      w_dec = '0;
      case (w_op)
         6'h00: begin
            case (w_funct)
               6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
               6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: begin
                  w_dec.regwrite = 1'b1; w_dec.regdst = 1'b1;
               end
               6'h08: begin w_dec.jump = 1'b1; w_dec.jr = 1'b1; end
               6'h09: begin w_dec.regwrite = 1'b1; w_dec.regdst = 1'b1; w_dec.jr = 1'b1; end
               6'h0c: w_dec.syscall = 1'b1;
               6'h0d: w_dec.brk = 1'b1;
               6'h10, 6'h12: begin
                  w_dec.regwrite = 1'b1; w_dec.regdst = 1'b1; w_dec.hlread = 1'b1;
               end
               6'h11, 6'h13: w_dec.hlwrite = 1'b1;
               6'h18, 6'h19: begin w_dec.hlwrite = 1'b1; w_dec.is_mul = 1'b1; end
               6'h1a, 6'h1b: begin w_dec.hlwrite = 1'b1; w_dec.is_div = 1'b1; end
               default: w_dec.ri = 1'b1;
            endcase
         end
         6'h01: begin
            case (w_rt)
               5'h00, 5'h01: w_dec.branch = 1'b1;
               5'h10, 5'h11: begin
                  w_dec.branch = 1'b1; w_dec.regwrite = 1'b1;
                  w_dec.bal = 1'b1; w_dec.write31 = 1'b1;
               end
               default: w_dec.ri = 1'b1;
            endcase
         end
         6'h02: w_dec.jump = 1'b1;
         6'h03: begin w_dec.regwrite = 1'b1; w_dec.jal = 1'b1; w_dec.write31 = 1'b1; end
         6'h04, 6'h05, 6'h06, 6'h07: w_dec.branch = 1'b1;
         6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
            w_dec.regwrite = 1'b1; w_dec.alusrc = 1'b1;
         end
         6'h10: begin
            if (bus.instr == 32'h4200_0018) begin
               w_dec.eret = 1'b1;
            end else if (w_rs == 5'd0 && bus.instr[10:0] == 11'd0) begin
               w_dec.regwrite = 1'b1; w_dec.cp0read = 1'b1;
            end else if (w_rs == 5'd4 && bus.instr[10:0] == 11'd0) begin
               w_dec.cp0we = 1'b1;
            end else begin
               w_dec.ri = 1'b1;
            end
         end
         // LB/LH/LW/LBU/LHU; unaligned LWL/LWR are not supported
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
            w_dec.regwrite = 1'b1; w_dec.alusrc = 1'b1;
            w_dec.memtoreg = 1'b1; w_dec.memen = 1'b1;
         end
         6'h28, 6'h29, 6'h2b: begin
            w_dec.alusrc = 1'b1; w_dec.memwrite = 1'b1; w_dec.memen = 1'b1;
         end
         default: w_dec.ri = 1'b1;
      endcase
   end

   assign md_busy       = (r_state != c_idle);
   assign w_hl_block    = md_busy & (w_dec.hlwrite | w_dec.hlread);
   assign bus.in_ready  = ~flush & (~r_valid | bus.out_ready) & ~w_hl_block;
   assign w_accept      = bus.in_valid & bus.in_ready;
   assign w_handoff     = r_valid & bus.out_ready;
   assign bus.out_valid = r_valid;
   assign bus.ctrl      = r_ctrl;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
         r_state <= c_idle;
         r_count <= '0;
      end else begin
         if (w_accept) begin
            r_valid <= 1'b1;
            r_ctrl  <= w_dec;
         end else if (flush || w_handoff) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
         end

         // a hand-off reloads the busy window; otherwise count down to idle
         if (w_handoff && r_ctrl.is_mul) begin
            r_state <= c_mul;
            r_count <= c_mul_init;
         end else if (w_handoff && r_ctrl.is_div) begin
            r_state <= c_div;
            r_count <= c_div_init;
         end else if (r_state != c_idle) begin
            if (r_count == '0) r_state <= c_idle;
            else               r_count <= r_count - CNT_W'(1);
         end
      end
   end

endmodule
`default_nettype wire
